// File: rtl/hilo_unit.sv
// HI/LO register unit: MULTU capture, MTHI/MTLO writes
// and a multi-cycle unsigned restoring divider (DIVU).
module hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] alu_r,
    input  logic [WIDTH-1:0] alu_r2,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] OP_MULTU = 2'd0;
    localparam logic [1:0] OP_DIVU  = 2'd1;
    localparam logic [1:0] OP_MTHI  = 2'd2;
    localparam logic [1:0] OP_MTLO  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_FIN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic [WIDTH:0]   rem_ext;
    logic [WIDTH:0]   trial;
    logic             step_ok;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    assign accept = op_valid & ~busy_q;

    // One restoring step; trial[WIDTH] is the borrow of the extended subtract.
    always_comb begin
        rem_ext  = {rem_q, quo_q[WIDTH-1]};
        trial    = rem_ext - {1'b0, div_q};
        step_ok  = ~trial[WIDTH];
        rem_step = step_ok ? trial[WIDTH-1:0] : rem_ext[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], step_ok};
    end

    // Next-state logic for the FSM and all architectural registers.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
        div_d   = div_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (op)
                        OP_MULTU: begin
                            lo_d = alu_r;
                            hi_d = alu_r2;
                        end
                        OP_DIVU: begin
                            if (b == '0) begin
                                hi_d   = a;
                                lo_d   = '1;
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                div_d   = b;
                                quo_d   = a;
                                rem_d   = '0;
                                cnt_d   = '0;
                                busy_d  = 1'b1;
                                state_d = S_DIV;
                            end
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                    endcase
                end
            end
            S_DIV: begin
                quo_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                hi_d    = rem_q;
                lo_d    = quo_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and register update; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            div_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: vector table with a
// scoreboard queue, plus hand-written multi-cycle sequences.
module tb_hilo_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         op_valid;
    logic [1:0]   op;
    logic [W-1:0] a, b, alu_r, alu_r2;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [W-1:0] r2;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
        logic         edone;
        logic         edbz;
        int           elat;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         done;
        logic         dbz;
        int           lat;
    } exp_t;

    vec_t tbl[9];
    exp_t sbq[$];

    hilo_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op         (op),
        .a          (a),
        .b          (b),
        .alu_r      (alu_r),
        .alu_r2     (alu_r2),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%h req=%h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] xa,
                         input logic [W-1:0] xb, input logic [W-1:0] xr,
                         input logic [W-1:0] xr2);
        op       = o;
        a        = xa;
        b        = xb;
        alu_r    = xr;
        alu_r2   = xr2;
        op_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        alu_r    = $urandom;
        alu_r2   = $urandom;
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        exp_t e;
        int   lat;
        sbq.push_back('{v.ehi, v.elo, v.edone, v.edbz, v.elat});
        issue(v.op, v.a, v.b, v.r, v.r2);
        lat = 0;
        while (busy === 1'b1 && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        e = sbq.pop_front();
        chk({nm, ".lat"}, W'(lat), W'(e.lat));
        chk({nm, ".hi"}, hi, e.hi);
        chk({nm, ".lo"}, lo, e.lo);
        chk({nm, ".done"}, W'(done), W'(e.done));
        chk({nm, ".dbz"}, W'(div_by_zero), W'(e.dbz));
        @(negedge clk);
        chk({nm, ".clr"}, W'({done, div_by_zero}), '0);
    endtask

    initial begin
        vec_t v;
        int   lat;
        int   seen;

        tbl[0] = '{2'd0, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFE,
                   32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 0};
        tbl[1] = '{2'd2, 32'h0000CAFE, 32'h0, 32'h0, 32'h0,
                   32'h0000CAFE, 32'h00000001, 1'b0, 1'b0, 0};
        tbl[2] = '{2'd3, 32'h0000BEEF, 32'h0, 32'h0, 32'h0,
                   32'h0000CAFE, 32'h0000BEEF, 1'b0, 1'b0, 0};
        tbl[3] = '{2'd1, 32'd100, 32'd7, 32'h0, 32'h0,
                   32'd2, 32'd14, 1'b1, 1'b0, 33};
        tbl[4] = '{2'd1, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0,
                   32'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 33};
        tbl[5] = '{2'd1, 32'd5, 32'hFFFFFFFF, 32'h0, 32'h0,
                   32'd5, 32'h0, 1'b1, 1'b0, 33};
        tbl[6] = '{2'd1, 32'h00001234, 32'h0, 32'h0, 32'h0,
                   32'h00001234, 32'hFFFFFFFF, 1'b1, 1'b1, 0};
        tbl[7] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
                   32'h0, 32'h1, 1'b1, 1'b0, 33};
        tbl[8] = '{2'd1, 32'hDEADBEEF, 32'h10, 32'h0, 32'h0,
                   32'hF, 32'h0DEADBEE, 1'b1, 1'b0, 33};

        rst_n    = 1'b0;
        op_valid = 1'b0;
        op       = 2'd0;
        a        = '0;
        b        = '0;
        alu_r    = '0;
        alu_r2   = '0;
        repeat (2) @(negedge clk);
        chk("rst.hilo", hi | lo, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.hi", hi, '0);
        chk("rst.lo", lo, '0);
        chk("rst.flags", W'({busy, done, div_by_zero}), '0);

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        for (int i = 0; i < 4; i++) begin
            v.op   = 2'd1;
            v.a    = $urandom;
            v.b    = (i == 0) ? W'($urandom_range(1, 255)) : $urandom;
            if (v.b == '0) v.b = 32'd3;
            v.r    = '0;
            v.r2   = '0;
            v.ehi  = v.a % v.b;
            v.elo  = v.a / v.b;
            v.edone = 1'b1;
            v.edbz = 1'b0;
            v.elat = 33;
            run_vec($sformatf("rnd%0d", i), v);
        end

        // MTHI while busy must be ignored; MTLO in the done cycle accepted.
        issue(2'd1, 32'd100, 32'd7, 32'h0, 32'h0);
        repeat (4) @(negedge clk);
        op       = 2'd2;
        a        = 32'h0000DEAD;
        op_valid = 1'b1;
        repeat (3) @(negedge clk);
        op_valid = 1'b0;
        lat = 0;
        while (busy === 1'b1 && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        chk("busy_mthi.done", W'(done), W'(1));
        chk("busy_mthi.hi", hi, 32'd2);
        chk("busy_mthi.lo", lo, 32'd14);
        op       = 2'd3;
        a        = 32'h00000055;
        op_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        chk("b2b.lo", lo, 32'h55);
        chk("b2b.hi", hi, 32'd2);
        chk("b2b.flags", W'({busy, done}), '0);

        // Reset in the middle of a division.
        issue(2'd1, 32'd100, 32'd7, 32'h0, 32'h0);
        repeat (10) @(negedge clk);
        chk("midrst.busy_pre", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst.hi", hi, '0);
        chk("midrst.lo", lo, '0);
        chk("midrst.flags", W'({busy, done, div_by_zero}), '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("midrst.quiet", W'(seen), '0);
        chk("midrst.hilo", hi | lo, '0);
        chk("sbq.empty", W'(sbq.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
